// File: rtl/ef_i2s_tx.sv
// ef_i2s_tx: I2S / left-justified serial audio transmitter with fixed 32-SCK slots
// Ports: clk, rst_n (async active-low); en gates all timing state;
//   sck_prescaler = SCK half-period minus one (clk cycles);
//   sample_size / left_justified / channels configure the format (sampled at slot start);
//   s_data / s_valid / s_ready = right-aligned sample stream (s_ready is combinational);
//   sck / ws / sdo = serial outputs; underrun = 1-clk pulse per starved slot;
//   underrun_flag = sticky underrun, cleared by underrun_clr.
module ef_i2s_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  sck_prescaler,
    input  logic [5:0]  sample_size,
    input  logic        left_justified,
    input  logic [1:0]  channels,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        underrun_clr,
    output logic        sck,
    output logic        ws,
    output logic        sdo,
    output logic        underrun,
    output logic        underrun_flag
);
    logic [7:0]  presc_q, presc_d;
    logic        sck_q, sck_d, ws_q, ws_d, sdo_q, sdo_d, lj_q, lj_d;
    logic [4:0]  bit_ctr_q, bit_ctr_d;
    logic [31:0] sr_q, sr_d;
    logic        underrun_q, underrun_d, flag_q, flag_d;
    logic        tick, fall_evt, slot_start, slot_en;
    logic [5:0]  ss_eff, shamt;
    always_comb begin
        tick       = en && presc_q == 8'd0;
        fall_evt   = tick && sck_q;
        slot_start = fall_evt && bit_ctr_q == 5'd0;
        // ws is about to toggle, so ws_q=1 means the new slot is the left one
        slot_en    = ws_q ? channels[1] : channels[0];
        ss_eff     = (sample_size == 6'd0 || sample_size > 6'd32) ? 6'd32 : sample_size;
        shamt      = 6'd32 - ss_eff;
        presc_d    = !en ? presc_q : tick ? sck_prescaler : presc_q - 8'd1;
        sck_d      = sck_q ^ tick;
        bit_ctr_d  = fall_evt ? bit_ctr_q + 5'd1 : bit_ctr_q;
        ws_d       = ws_q ^ slot_start;
        lj_d       = slot_start ? left_justified : lj_q;
        // I2S delay stage: captures the outgoing MSB one SCK late
        sdo_d      = fall_evt ? sr_q[31] : sdo_q;
        sr_d       = !fall_evt ? sr_q :
                     !slot_start ? {sr_q[30:0], 1'b0} :
                     (slot_en && s_valid) ? s_data << shamt[4:0] : 32'd0;
        s_ready    = slot_start && slot_en;
        underrun_d = s_ready && !s_valid;
        flag_d     = underrun_d || (flag_q && !underrun_clr);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= 8'd0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b1;
            bit_ctr_q  <= 5'd0;
            sr_q       <= 32'd0;
            sdo_q      <= 1'b0;
            lj_q       <= 1'b0;
            underrun_q <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            bit_ctr_q  <= bit_ctr_d;
            sr_q       <= sr_d;
            sdo_q      <= sdo_d;
            lj_q       <= lj_d;
            underrun_q <= underrun_d;
            flag_q     <= flag_d;
        end
    end
    assign sck           = sck_q;
    assign ws            = ws_q;
    assign sdo           = lj_q ? sr_q[31] : sdo_q;
    assign underrun      = underrun_q;
    assign underrun_flag = flag_q;
endmodule

// File: tb/tb_ef_i2s_tx.sv
// tb_ef_i2s_tx: table-driven and randomized checks of ef_i2s_tx against a frame-arithmetic model
`timescale 1ns/1ps
module tb_ef_i2s_tx;
    logic        clk = 1'b0;
    logic        rst_n, en, left_justified, s_valid, underrun_clr;
    logic [7:0]  sck_prescaler;
    logic [5:0]  sample_size;
    logic [1:0]  channels;
    logic [31:0] s_data;
    logic        s_ready, sck, ws, sdo, underrun, underrun_flag;

    ef_i2s_tx dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sck_prescaler(sck_prescaler),
        .sample_size(sample_size), .left_justified(left_justified), .channels(channels),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .underrun_clr(underrun_clr),
        .sck(sck), .ws(ws), .sdo(sdo), .underrun(underrun), .underrun_flag(underrun_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          p;
        bit          lj;
        int          ss;
        bit [1:0]    ch;
        logic [31:0] dl, dr;
        bit          vl, fz, mr;
        logic [31:0] expl, expr;
    } vec_t;

    vec_t        vt[8];
    int          checks = 0, errors = 0;
    int          pm, sse, n, tt, ff, cnt, prev_t;
    bit          lj_m, ur_m, flag_m;
    bit [1:0]    ch_m;
    logic [31:0] dat[128];
    bit          vld[128];
    logic [63:0] cap;
    int          bad[6];

    // Model: everything follows from n = enabled clk edges since reset.
    // tt = SCK toggles, ff = SCK falls, cnt = slot starts so far.
    task automatic upd();
        tt  = (n + pm) / (pm + 1);
        ff  = tt / 2;
        cnt = (ff + 31) / 32;
    endtask

    task automatic mreset();
        n = 0; ur_m = 0; flag_m = 0; prev_t = 0;
        upd();
    endtask

    function automatic bit slot_on(int s);
        return (s % 2 == 1) ? ch_m[1] : ch_m[0];
    endfunction

    function automatic logic [31:0] word(int s);
        int k;
        k = (s > 127) ? 127 : s;
        if (k <= 0) return 32'd0;
        return (vld[k] && slot_on(k)) ? dat[k] << (32 - sse) : 32'd0;
    endfunction

    function automatic bit exp_sdo();
        int j;
        logic [31:0] w;
        if (cnt == 0) return 1'b0;
        j = ff - 1 - 32 * (cnt - 1);
        w = word(cnt);
        if (lj_m) return w[31 - j];
        if (j == 0) begin
            w = word(cnt - 1);
            return w[0];
        end
        return w[32 - j];
    endfunction

    function automatic bit slot_next();
        return (n % (pm + 1) == 0) && (tt % 2 == 1) && (ff % 32 == 0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input int p, input bit lj, input int ss, input bit [1:0] ch,
                       input bit rnd, input bit fz, input bit mr, input int cyc);
        int       fz_left, fz_bad, idx, pos;
        bit       fz_done, rdy_e;
        logic [2:0] held;
        fz_left = 0; fz_bad = 0; fz_done = 0; held = '0;
        pm = p; lj_m = lj; ch_m = ch; sse = (ss == 0 || ss > 32) ? 32 : ss;
        foreach (bad[i]) bad[i] = 0;
        cap = '0;
        rst_n = 0; en = 0; s_valid = 0; s_data = '0; underrun_clr = 0;
        sck_prescaler = p[7:0]; sample_size = ss[5:0]; left_justified = lj; channels = ch;
        mreset();
        repeat (2) @(posedge clk);
        #1 chk("reset state", {sck, ws, sdo, s_ready, underrun, underrun_flag}, 6'b010000);
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < cyc; c++) begin
            if (mr && c == cyc / 2) begin
                @(negedge clk);
                rst_n = 0;
                #1 chk("async reset mid-frame", {sck, ws, sdo, s_ready, underrun, underrun_flag}, 6'b010000);
                mreset();
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1;
            end
            if (fz && !fz_done && cnt == 1 && ff == 10 && tt % 2 == 0) begin
                fz_done = 1;
                fz_left = 20;
                held = {(tt % 2 == 1), (cnt % 2 == 0), exp_sdo()};
            end
            idx = (cnt + 1 > 127) ? 127 : cnt + 1;
            en = (fz_left > 0) ? 1'b0 : rnd ? ($urandom_range(0, 6) != 0) : 1'b1;
            s_valid = vld[idx];
            s_data = vld[idx] ? dat[idx] : $urandom;
            underrun_clr = rnd ? ($urandom_range(0, 19) == 0) : 1'b0;
            #1;
            rdy_e = en && slot_next() && slot_on(cnt + 1);
            if (sck !== (tt % 2 == 1)) bad[0]++;
            if (ws !== (cnt % 2 == 0)) bad[1]++;
            if (sdo !== exp_sdo()) bad[2]++;
            if (s_ready !== rdy_e) bad[3]++;
            if (underrun !== ur_m) bad[4]++;
            if (underrun_flag !== flag_m) bad[5]++;
            if (fz_left > 0) begin
                if ({sck, ws, sdo} !== held) fz_bad++;
                fz_left--;
            end
            @(posedge clk);
            #1;
            ur_m = en && slot_next() && slot_on(cnt + 1) && !s_valid;
            flag_m = ur_m || (flag_m && !underrun_clr);
            if (en) n++;
            upd();
            // receiver view: sample sdo on each SCK rise, indexed by stream position
            if (tt != prev_t && tt % 2 == 1) begin
                pos = lj ? ff - 1 : ff - 2;
                if (pos >= 0 && pos < 64) cap[63 - pos] = sdo;
            end
            prev_t = tt;
        end
        chk("sck mismatch cycles", bad[0], 0);
        chk("ws mismatch cycles", bad[1], 0);
        chk("sdo mismatch cycles", bad[2], 0);
        chk("s_ready mismatch cycles", bad[3], 0);
        chk("underrun mismatch cycles", bad[4], 0);
        chk("underrun_flag mismatch cycles", bad[5], 0);
        if (fz) chk("outputs held while en=0", fz_bad, 0);
    endtask

    initial begin
        //        p  lj ss  ch     dl            dr            vl fz mr expl          expr
        vt[0] = '{1, 0, 32, 2'b11, 32'hA5A50001, 32'h80000001, 1, 0, 0, 32'hA5A50001, 32'h80000001};
        vt[1] = '{0, 1, 16, 2'b11, 32'h0000BEEF, 32'h0000BEEF, 1, 0, 0, 32'hBEEF0000, 32'hBEEF0000};
        vt[2] = '{2, 0, 0,  2'b10, 32'h12345678, 32'hCAFEF00D, 1, 0, 1, 32'h12345678, 32'h00000000};
        vt[3] = '{0, 1, 40, 2'b01, 32'hFFFFFFFF, 32'h0F0F0F0F, 1, 0, 0, 32'h00000000, 32'h0F0F0F0F};
        vt[4] = '{3, 0, 8,  2'b11, 32'h000000A5, 32'h0000003C, 1, 1, 0, 32'hA5000000, 32'h3C000000};
        vt[5] = '{0, 0, 1,  2'b00, 32'h00000001, 32'h00000001, 1, 0, 0, 32'h00000000, 32'h00000000};
        vt[6] = '{1, 1, 24, 2'b11, 32'h00ABCDEF, 32'h12FEDCBA, 1, 0, 0, 32'hABCDEF00, 32'hFEDCBA00};
        vt[7] = '{1, 1, 32, 2'b11, 32'hDEADBEEF, 32'h01234567, 0, 0, 0, 32'h00000000, 32'h01234567};
        for (int v = 0; v < 8; v++) begin
            for (int s = 0; s < 128; s++) begin
                dat[s] = (s % 2 == 1) ? vt[v].dl : vt[v].dr;
                vld[s] = (s % 2 == 1) ? vt[v].vl : 1'b1;
            end
            run(vt[v].p, vt[v].lj, vt[v].ss, vt[v].ch, 1'b0, vt[v].fz, vt[v].mr,
                (140 * (vt[v].p + 1) + 40) * (vt[v].mr ? 2 : 1));
            chk($sformatf("vec%0d left word", v), cap[63:32], vt[v].expl);
            chk($sformatf("vec%0d right word", v), cap[31:0], vt[v].expr);
        end
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 128; s++) begin
                dat[s] = $urandom;
                vld[s] = ($urandom_range(0, 4) != 0);
            end
            run($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 40),
                2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0, 1500);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ef_i2s_tx.md
EF_I2S_TX -- requirements
Module: ef_i2s_tx

Interface
REQ-001 Parameters: none; slot width is fixed at 32 SCK cycles and the data word is fixed at 32 bits.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state changes on posedge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 en  in  1  enable; when 0, all timing state holds.
REQ-006 sck_prescaler  in  8  half-period of SCK minus one, in clk cycles.
REQ-007 sample_size  in  6  valid bits per sample; 0 or values above 32 are treated as 32.
REQ-008 left_justified  in  1  1 = left-justified format, 0 = standard I2S (one-SCK MSB delay).
REQ-009 channels  in  2  10 = left only, 01 = right only, 11 = stereo, 00 = none.
REQ-010 s_data  in  32  sample word, right-aligned (LSB-justified).
REQ-011 s_valid  in  1  s_data is valid.
REQ-012 s_ready  out  1  consume strobe; a transfer occurs in a clk cycle where s_valid and s_ready are both 1.
REQ-013 underrun_clr  in  1  clears underrun_flag.
REQ-014 sck  out  1  serial clock.
REQ-015 ws  out  1  word select; 0 = left, 1 = right.
REQ-016 sdo  out  1  serial data out.
REQ-017 underrun  out  1  one-clk pulse per starved slot.
REQ-018 underrun_flag  out  1  sticky underrun indicator.

Function
REQ-019 Prescaler: when en=1 and the prescaler is 0, it reloads sck_prescaler; otherwise it decrements; SCK period = 2*(sck_prescaler+1) clk.
REQ-020 sck toggles on each clk where en=1 and the prescaler is 0; fall_evt = that condition with sck=1.
REQ-021 A 5-bit bit_ctr increments on fall_evt and wraps 31->0; a slot = 32 SCK, a frame = 64 SCK.
REQ-022 ws toggles on fall_evt when bit_ctr=0; this is the slot-start event.
REQ-023 At slot start, the slot is enabled when (new ws=0 and channels[1]) or (new ws=1 and channels[0]).
REQ-024 s_ready is combinational: 1 only during a slot-start clk of an enabled slot, otherwise 0.
REQ-025 At slot start of an enabled slot with s_valid=1, the 32-bit shift register loads s_data << (32-sample_size); bits below sample_size transmit as 0.
REQ-026 At slot start of an enabled slot with s_valid=0, the shift register loads 0, underrun pulses for 1 clk, and underrun_flag sets.
REQ-027 At slot start of a disabled slot, the shift register loads 0 with no transfer and no underrun.
REQ-028 On every non-slot-start fall_evt, the shift register shifts left by 1, filling with 0.
REQ-029 Left-justified mode: sdo = shift register bit 31, so the MSB appears on the same SCK falling edge as the ws change.
REQ-030 I2S mode: sdo = a copy of shift register bit 31 registered on fall_evt, so the MSB appears one SCK after the ws change.
REQ-031 sdo changes only on fall_evt; the receiver samples on the SCK rising edge.
REQ-032 underrun_flag clears on underrun_clr; if set and clear coincide in one clk, set wins.
REQ-033 en=0 mid-slot freezes prescaler, sck, ws, bit_ctr, shift register and sdo; on re-enable the bit stream resumes with no lost or duplicated bits.
REQ-034 Changes to sample_size, left_justified or channels take effect at the next slot start only.

Reset
REQ-035 On rst_n=0: prescaler=0, sck=0, ws=1, bit_ctr=0, shift register=0, sdo=0, underrun=0, underrun_flag=0; s_ready=0.
REQ-036 Reset applies immediately, asynchronously, including mid-frame.
REQ-037 After reset, the first fall_evt starts a left slot.

Verification
REQ-038 sck_prescaler=1, en=1, channels=11, I2S mode, sample_size=32; left word 0xA5A50001, right word 0x80000001 -> SCK period 4 clk; ws low for 32 SCK; sdo = 0xA5A50001 MSB-first starting one SCK after the ws fall; exactly 2 s_ready pulses per 64 SCK.
REQ-039 left_justified=1, sample_size=16, s_data=0x0000BEEF -> sdo = 1011111011101111 followed by 16 zeros, MSB coincident with the ws edge.
REQ-040 channels=10, s_valid=1 held -> s_ready pulses only at left slot starts; right slots output all 0; underrun stays 0.
REQ-041 s_valid=0 at a left slot start -> underrun high 1 clk; underrun_flag=1 until underrun_clr; that slot outputs 32 zeros; the next slot with valid data transmits normally.
REQ-042 en=0 for 20 clk after the 10th bit of a slot -> sck, ws and sdo constant throughout; after en=1 the 11th bit follows with the correct total slot length.
REQ-043 rst_n pulsed low mid-frame -> all outputs at reset values in the same cycle; after release, the stream restarts with a left slot.
